// File: rtl/div_issue_ctrl_if.sv
// rtl/div_issue_ctrl_if.sv - request/result handshake bundle for div_issue_ctrl
//
// Carries the upstream request stream and the downstream result stream.
//   in_valid/in_ready       request handshake
//   in_dividend/in_divisor  request operands (2*WIDTH / WIDTH bits)
//   out_valid/out_ready     result handshake
//   out_quotient            result quotient (2*WIDTH bits)
//   out_remainder           result remainder (WIDTH bits)
//   out_dbz                 result was a divide-by-zero
// slave modport: the controller side. master modport: the requester/consumer side.
interface div_issue_ctrl_if #(
    parameter int WIDTH = 4
);
    logic                   in_valid;
    logic                   in_ready;
    logic [2*WIDTH-1:0]     in_dividend;
    logic [WIDTH-1:0]       in_divisor;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*WIDTH-1:0]     out_quotient;
    logic [WIDTH-1:0]       out_remainder;
    logic                   out_dbz;

    modport slave (
        input  in_valid, in_dividend, in_divisor, out_ready,
        output in_ready, out_valid, out_quotient, out_remainder, out_dbz
    );

    modport master (
        output in_valid, in_dividend, in_divisor, out_ready,
        input  in_ready, out_valid, out_quotient, out_remainder, out_dbz
    );
endinterface

// File: rtl/div_issue_ctrl.sv
// rtl/div_issue_ctrl.sv - issues one request at a time to a fixed-latency divider
//
// Accepts a request, starts an external fixed-latency divider with a one-cycle
// pulse, captures its result exactly LATENCY cycles after that pulse and holds
// it on a valid/ready result port. Zero divisors bypass the divider and return
// quotient all-ones, remainder = low WIDTH bits of the dividend, out_dbz = 1.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   bus             request/result handshake bundle (slave side)
//   div_dividend    registered dividend to the divider
//   div_divisor     registered divisor to the divider
//   div_din_valid   registered single-cycle divider start pulse
//   div_dout        divider quotient
//   div_remainder   divider remainder
//   busy            high whenever the controller is not IDLE
module div_issue_ctrl #(
    parameter int WIDTH   = 4,
    parameter int LATENCY = 5 * WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    div_issue_ctrl_if.slave      bus,
    output logic [2*WIDTH-1:0]   div_dividend,
    output logic [WIDTH-1:0]     div_divisor,
    output logic                 div_din_valid,
    input  logic [2*WIDTH-1:0]   div_dout,
    input  logic [WIDTH-1:0]     div_remainder,
    output logic                 busy
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    // LATENCY is at most 255, so eight bits always hold the terminal count.
    localparam logic [7:0] LAT = 8'(LATENCY);

    state_t     state;
    logic [7:0] cnt;

    assign bus.in_ready = (state == IDLE);
    assign busy         = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            cnt               <= 8'd0;
            div_din_valid     <= 1'b0;
            div_dividend      <= '0;
            div_divisor       <= '0;
            bus.out_valid     <= 1'b0;
            bus.out_quotient  <= '0;
            bus.out_remainder <= '0;
            bus.out_dbz       <= 1'b0;
        end else begin
            // Start pulse lasts only the first WAIT cycle.
            div_din_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        div_dividend <= bus.in_dividend;
                        div_divisor  <= bus.in_divisor;
                        cnt          <= 8'd0;
                        if (bus.in_divisor == '0) begin
                            bus.out_quotient  <= '1;
                            bus.out_remainder <= bus.in_dividend[WIDTH-1:0];
                            bus.out_dbz       <= 1'b1;
                            bus.out_valid     <= 1'b1;
                            state             <= DONE;
                        end else begin
                            div_din_valid <= 1'b1;
                            state         <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    // cnt reads k during cycle k+1 after the pulse cycle, so
                    // cnt==LAT marks the edge closing the LATENCY-th cycle.
                    if (cnt == LAT) begin
                        bus.out_quotient  <= div_dout;
                        bus.out_remainder <= div_remainder;
                        bus.out_dbz       <= 1'b0;
                        bus.out_valid     <= 1'b1;
                        state             <= DONE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb/tb_div_issue_ctrl.sv - self-checking bench for div_issue_ctrl
module tb_div_issue_ctrl;
    localparam int W   = 4;
    localparam int LAT = 20;

    logic         clk;
    logic         rst;
    logic [7:0]   div_dividend;
    logic [3:0]   div_divisor;
    logic         div_din_valid;
    logic [7:0]   div_dout;
    logic [3:0]   div_remainder;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    div_issue_ctrl_if #(.WIDTH(W)) bus ();

    div_issue_ctrl #(.WIDTH(W), .LATENCY(LAT)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_din_valid (div_din_valid),
        .div_dout      (div_dout),
        .div_remainder (div_remainder),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Divider model: correct result only during the LATENCY-th cycle after the
    // pulse cycle (covering the capture edge), random junk at all other times.
    logic [7:0] m_dd;
    logic [3:0] m_dv;
    int         mcnt = 0;
    initial begin
        div_dout      = 8'd0;
        div_remainder = 4'd0;
        m_dd          = 8'd0;
        m_dv          = 4'd0;
    end
    always @(negedge clk) begin
        if (rst) begin
            mcnt = 0;
        end else if (div_din_valid) begin
            mcnt = 1;
            m_dd = div_dividend;
            m_dv = div_divisor;
        end else if (mcnt > 0) begin
            mcnt++;
        end
        if (mcnt == LAT + 1 && m_dv != 4'd0) begin
            div_dout      = m_dd / m_dv;
            div_remainder = m_dd % m_dv;
        end else begin
            div_dout      = 8'($urandom);
            div_remainder = 4'($urandom);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_reset_state();
        check_eq("rst_in_ready", 32'(bus.in_ready), 1);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_out_valid", 32'(bus.out_valid), 0);
        check_eq("rst_din_valid", 32'(div_din_valid), 0);
        check_eq("rst_div_dividend", 32'(div_dividend), 0);
        check_eq("rst_div_divisor", 32'(div_divisor), 0);
        check_eq("rst_quotient", 32'(bus.out_quotient), 0);
        check_eq("rst_remainder", 32'(bus.out_remainder), 0);
        check_eq("rst_dbz", 32'(bus.out_dbz), 0);
    endtask

    // Called at a negedge. Presents a request, follows it to handoff and
    // returns at the negedge after the handoff edge. With preload set, the
    // next request nd/nv is already driven during the handoff cycle.
    task automatic run_req(input logic [7:0] dd, input logic [3:0] dv, input int hold,
                           input bit preload, input logic [7:0] nd, input logic [3:0] nv);
        int         t, k, pulses, elat;
        logic [7:0] eq;
        logic [3:0] er;
        logic       ed;
        eq   = (dv == 4'd0) ? 8'hFF : dd / dv;
        er   = (dv == 4'd0) ? dd[3:0] : dd % dv;
        ed   = (dv == 4'd0);
        elat = (dv == 4'd0) ? 1 : LAT + 2;

        bus.out_ready   = (hold == 0);
        bus.in_valid    = 1'b1;
        bus.in_dividend = dd;
        bus.in_divisor  = dv;
        t = 0;
        while (!bus.in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        check_eq("accept_timeout", 32'(t < 200), 1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid    = 1'b0;
        bus.in_dividend = 8'($urandom);
        bus.in_divisor  = 4'($urandom);

        k = 1;
        pulses = 0;
        while (!bus.out_valid && k <= LAT + 10) begin
            if (div_din_valid) begin
                pulses++;
                check_eq("pulse_cycle", 32'(k), 1);
            end
            check_eq("wait_busy", 32'(busy), 1);
            check_eq("op_dividend_stable", 32'(div_dividend), 32'(dd));
            check_eq("op_divisor_stable", 32'(div_divisor), 32'(dv));
            @(negedge clk);
            k++;
        end
        check_eq("latency", 32'(k), 32'(elat));
        check_eq("pulse_count", 32'(pulses), 32'(dv != 4'd0));
        check_eq("quotient", 32'(bus.out_quotient), 32'(eq));
        check_eq("remainder", 32'(bus.out_remainder), 32'(er));
        check_eq("dbz", 32'(bus.out_dbz), 32'(ed));
        check_eq("done_in_ready", 32'(bus.in_ready), 0);
        check_eq("done_din_valid", 32'(div_din_valid), 0);

        for (int i = 0; i < hold; i++) begin
            bus.in_valid    = 1'($urandom_range(0, 1));
            bus.in_dividend = 8'($urandom);
            bus.in_divisor  = 4'($urandom);
            @(negedge clk);
            check_eq("hold_valid", 32'(bus.out_valid), 1);
            check_eq("hold_quotient", 32'(bus.out_quotient), 32'(eq));
            check_eq("hold_remainder", 32'(bus.out_remainder), 32'(er));
            check_eq("hold_dbz", 32'(bus.out_dbz), 32'(ed));
            check_eq("hold_in_ready", 32'(bus.in_ready), 0);
        end

        bus.out_ready = 1'b1;
        if (preload) begin
            bus.in_valid    = 1'b1;
            bus.in_dividend = nd;
            bus.in_divisor  = nv;
        end else begin
            bus.in_valid = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        check_eq("handoff_valid_low", 32'(bus.out_valid), 0);
        check_eq("handoff_idle", 32'(busy), 0);
        check_eq("handoff_in_ready", 32'(bus.in_ready), 1);
    endtask

    initial begin
        logic [7:0] rd;
        logic [3:0] rv;

        rst             = 1'b1;
        bus.in_valid    = 1'b0;
        bus.in_dividend = 8'd0;
        bus.in_divisor  = 4'd0;
        bus.out_ready   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_reset_state();

        run_req(8'd100, 4'd7, 0, 1'b0, 8'd0, 4'd0);
        run_req(8'd255, 4'd1, 0, 1'b1, 8'd0, 4'd15);
        run_req(8'd0, 4'd15, 0, 1'b0, 8'd0, 4'd0);
        run_req(8'd77, 4'd0, 0, 1'b0, 8'd0, 4'd0);
        run_req(8'd200, 4'd9, 5, 1'b0, 8'd0, 4'd0);

        // Reset 10 cycles into WAIT, with in_valid also high to exercise priority.
        bus.out_ready   = 1'b1;
        bus.in_valid    = 1'b1;
        bus.in_dividend = 8'd123;
        bus.in_divisor  = 4'd5;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (9) @(negedge clk);
        check_eq("pre_reset_busy", 32'(busy), 1);
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        check_reset_state();
        for (int i = 0; i < LAT + 8; i++) begin
            @(negedge clk);
            if (bus.out_valid) check_eq("no_valid_after_reset", 32'(bus.out_valid), 0);
        end
        check_eq("idle_after_reset", 32'(busy), 0);
        run_req(8'd50, 4'd3, 0, 1'b0, 8'd0, 4'd0);

        for (int n = 0; n < 1000; n++) begin
            rd = 8'($urandom);
            rv = 4'($urandom_range(0, 15));
            run_req(rd, rv, int'($urandom_range(0, 3)), 1'b0, 8'd0, 4'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/div_issue_ctrl.md
DIV_ISSUE_CTRL -- requirements
Module: div_issue_ctrl

Interface
REQ-001 Parameter: WIDTH, default 4, divisor width; dividend and quotient are 2*WIDTH bits.
REQ-002 Parameter: LATENCY, default 5*WIDTH, cycles from div_din_valid high to divider result stable; legal range 1..255.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  upstream request valid.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 in_dividend  input  2*WIDTH  request dividend.
REQ-008 in_divisor  input  WIDTH  request divisor.
REQ-009 div_dividend  output  2*WIDTH  operand to downstream divider, registered.
REQ-010 div_divisor  output  WIDTH  operand to downstream divider, registered.
REQ-011 div_din_valid  output  1  single-cycle start pulse to divider, registered.
REQ-012 div_dout  input  2*WIDTH  divider quotient.
REQ-013 div_remainder  input  WIDTH  divider remainder.
REQ-014 out_valid  output  1  result valid.
REQ-015 out_ready  input  1  consumer accepts result.
REQ-016 out_quotient  output  2*WIDTH  result quotient.
REQ-017 out_remainder  output  WIDTH  result remainder.
REQ-018 out_dbz  output  1  result is divide-by-zero.
REQ-019 busy  output  1  high in any state other than IDLE.

Function
REQ-020 FSM states SHALL be IDLE, WAIT, DONE; in_ready SHALL equal (state==IDLE).
REQ-021 Accept SHALL occur on an edge where in_valid && in_ready; in_dividend/in_divisor SHALL be latched into div_dividend/div_divisor on that edge.
REQ-022 Accept with in_divisor!=0: next state WAIT; div_din_valid SHALL be high for exactly the first cycle of WAIT and low otherwise.
REQ-023 Accept with in_divisor==0: next state DONE directly; divider SHALL NOT be started; out_quotient = all ones, out_remainder = in_dividend[WIDTH-1:0], out_dbz = 1.
REQ-024 WAIT: a cycle counter SHALL count the cycles from div_din_valid; div_dout/div_remainder SHALL be captured on the edge ending the LATENCY-th cycle after the div_din_valid cycle, with out_dbz = 0; next state DONE.
REQ-025 Latency: non-zero divisor, out_valid SHALL rise LATENCY+2 cycles after the accept edge; zero divisor, 1 cycle after.
REQ-026 div_dividend/div_divisor SHALL remain stable from accept until leaving WAIT.
REQ-027 DONE: out_valid = 1; out_quotient/out_remainder/out_dbz SHALL hold stable while out_valid && !out_ready.
REQ-028 On edge with out_valid && out_ready: next state IDLE, out_valid low next cycle; a new request SHALL be accepted no earlier than the following edge.
REQ-029 in_valid while busy SHALL be ignored without side effects.
REQ-030 Changes on div_dout/div_remainder outside the capture edge SHALL NOT affect outputs.

Reset
REQ-031 rst high at an edge SHALL force state IDLE and counter 0, and clear div_din_valid, out_valid, out_dbz, out_quotient, out_remainder, div_dividend, div_divisor to 0; busy 0, in_ready 1 on the cycle after.
REQ-032 Reset in WAIT or DONE SHALL discard the in-flight transaction; no out_valid SHALL result from it.
REQ-033 rst has priority over every other input in the same cycle.

Verification (WIDTH=4, LATENCY=20, bench divider model returns result exactly LATENCY cycles after pulse)
REQ-034 100/7, out_ready=1 -> one div_din_valid pulse; out_quotient=14, out_remainder=2, out_dbz=0; out_valid 22 cycles after accept, for 1 cycle.
REQ-035 255/1 then 0/15 back-to-back -> 255 r0, then 0 r0; second accept no earlier than the edge after first handoff.
REQ-036 77/0 -> no div_din_valid; out_valid 1 cycle after accept with quotient 8'hFF, remainder 4'hD, out_dbz=1.
REQ-037 200/9 with out_ready low 5 cycles in DONE -> outputs hold 22 r2 throughout; in_ready stays 0; in_valid pulses ignored.
REQ-038 rst pulsed 10 cycles into WAIT -> all outputs 0 next cycle, no out_valid ever for that request; subsequent 50/3 returns 16 r2.
REQ-039 Random 1000 requests, divisor 0..15, random out_ready -> every result matches integer / and %, dbz rule for 0.
